// File: rtl/pattern_count_fsm.sv
// Masked pattern match counter that replays counted matches as hit events under ready/valid backpressure.
// Optional abort input and logic are enabled by defining PCF_ABORT_EN.
module pattern_count_fsm #(
  parameter int unsigned DW = 4,
  parameter int unsigned CW = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          valid,
  input  logic [DW-1:0] num,
  input  logic [DW-1:0] seq,
  input  logic [DW-1:0] mask,
  input  logic          hit_ready,
`ifdef PCF_ABORT_EN
  input  logic          abort,
`endif
  output logic [1:0]    state,
  output logic [CW-1:0] cnt,
  output logic          hit,
  output logic          busy,
  output logic          ovf
);

  typedef enum logic [1:0] {
    S_WAIT   = 2'd0,
    S_WATCH  = 2'd1,
    S_ASSERT = 2'd2
  } state_e;

  localparam logic [CW-1:0] CNT_MAX = '1;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;

  logic          match_c;
  logic          cnt_sat_c;
  logic [CW-1:0] cnt_inc_c;

  assign match_c   = valid && (((num ^ seq) & mask) == '0);
  assign cnt_sat_c = (cnt_q == CNT_MAX);
  assign cnt_inc_c = cnt_sat_c ? cnt_q : cnt_q + CW'(1);

  // State, count and overflow registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_WAIT;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state, counting and overflow tracking
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_WAIT: begin
        if (valid) begin
          state_d = S_WATCH;
          ovf_d   = match_c && cnt_sat_c;
          if (match_c) cnt_d = cnt_inc_c;
        end
      end
      S_WATCH: begin
        if (valid) begin
          if (match_c) begin
            cnt_d = cnt_inc_c;
            if (cnt_sat_c) ovf_d = 1'b1;
          end
        end else if (cnt_q != '0) begin
          state_d = S_ASSERT;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_ASSERT: begin
        // Samples are ignored here; only the hit handshake moves the count.
        if (hit_ready) begin
          if (cnt_q <= CW'(1)) begin
            state_d = S_WAIT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
      end
      default: begin
        state_d = S_WAIT;
      end
    endcase
`ifdef PCF_ABORT_EN
    if (abort) begin
      state_d = S_WAIT;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end
`endif
  end

  assign state = state_q;
  assign cnt   = cnt_q;
  assign ovf   = ovf_q;
  assign hit   = (state_q == S_ASSERT);
  assign busy  = (state_q == S_ASSERT);

endmodule

// File: tb/tb_pattern_count_fsm.sv
// Directed self-checking bench for pattern_count_fsm (DW=CW=4); abort steps run when PCF_ABORT_EN is defined.
module tb_pattern_count_fsm;

  logic       clock;
  logic       reset;
  logic       valid;
  logic [3:0] num;
  logic [3:0] seq;
  logic [3:0] mask;
  logic       hit_ready;
`ifdef PCF_ABORT_EN
  logic       abort;
`endif
  logic [1:0] state;
  logic [3:0] cnt;
  logic       hit;
  logic       busy;
  logic       ovf;

  int checks;
  int failures;
  int hit_cycles;

  pattern_count_fsm #(.DW(4), .CW(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .valid     (valid),
    .num       (num),
    .seq       (seq),
    .mask      (mask),
    .hit_ready (hit_ready),
`ifdef PCF_ABORT_EN
    .abort     (abort),
`endif
    .state     (state),
    .cnt       (cnt),
    .hit       (hit),
    .busy      (busy),
    .ovf       (ovf)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [1:0] e_state, input logic [3:0] e_cnt,
                         input logic e_ovf);
    chk({tag, ".state"}, 32'(state), 32'(e_state));
    chk({tag, ".cnt"},   32'(cnt),   32'(e_cnt));
    chk({tag, ".hit"},   32'(hit),   32'(e_state == 2'd2));
    chk({tag, ".busy"},  32'(busy),  32'(e_state == 2'd2));
    chk({tag, ".ovf"},   32'(ovf),   32'(e_ovf));
  endtask

  // Advance one clock; outputs are then sampled 1ns after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] n);
    valid = v;
    num   = n;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    valid     = 1'b0;
    num       = 4'h0;
    seq       = 4'h5;
    mask      = 4'hF;
    hit_ready = 1'b1;
`ifdef PCF_ABORT_EN
    abort     = 1'b0;
`endif
    #2;
    chk_all("reset", 2'd0, 4'd0, 1'b0);
    tick();
    reset = 1'b0;
    tick();
    chk_all("idle", 2'd0, 4'd0, 1'b0);

    // Basic burst: 5,3,5,5 against seq=5
    drive(1, 4'h5); tick(); chk_all("basic.s0", 2'd1, 4'd1, 1'b0);
    drive(1, 4'h3); tick(); chk_all("basic.s1", 2'd1, 4'd1, 1'b0);
    drive(1, 4'h5); tick(); chk_all("basic.s2", 2'd1, 4'd2, 1'b0);
    drive(1, 4'h5); tick(); chk_all("basic.s3", 2'd1, 4'd3, 1'b0);
    drive(0, 4'h0); tick(); chk_all("basic.a3", 2'd2, 4'd3, 1'b0);
    tick(); chk_all("basic.a2", 2'd2, 4'd2, 1'b0);
    tick(); chk_all("basic.a1", 2'd2, 4'd1, 1'b0);
    tick(); chk_all("basic.done", 2'd0, 4'd0, 1'b0);

    // No match goes WATCH -> WAIT without hit
    drive(1, 4'h1); tick(); chk_all("nomatch.s0", 2'd1, 4'd0, 1'b0);
    drive(1, 4'h2); tick(); chk_all("nomatch.s1", 2'd1, 4'd0, 1'b0);
    drive(1, 4'h3); tick(); chk_all("nomatch.s2", 2'd1, 4'd0, 1'b0);
    drive(0, 4'h0); tick(); chk_all("nomatch.end", 2'd0, 4'd0, 1'b0);
    tick(); chk_all("nomatch.idle", 2'd0, 4'd0, 1'b0);

    // Backpressure: ready 1,0,0,1 with samples offered while stalled
    drive(1, 4'h5); tick();
    drive(1, 4'h5); tick(); chk_all("bp.fill", 2'd1, 4'd2, 1'b0);
    drive(0, 4'h0); tick(); chk_all("bp.c0", 2'd2, 4'd2, 1'b0);
    hit_ready = 1'b1; tick(); chk_all("bp.c1", 2'd2, 4'd1, 1'b0);
    hit_ready = 1'b0; drive(1, 4'h5); tick(); chk_all("bp.c2", 2'd2, 4'd1, 1'b0);
    hit_ready = 1'b0; tick(); chk_all("bp.c3", 2'd2, 4'd1, 1'b0);
    hit_ready = 1'b1; drive(0, 4'h0); tick(); chk_all("bp.done", 2'd0, 4'd0, 1'b0);

    // Saturation, started back-to-back in the single WAIT cycle
    for (int i = 1; i <= 17; i++) begin
      drive(1, 4'h5);
      tick();
      if (i == 15) chk_all("sat.15", 2'd1, 4'd15, 1'b0);
      if (i == 16) chk_all("sat.16", 2'd1, 4'd15, 1'b1);
    end
    chk_all("sat.17", 2'd1, 4'd15, 1'b1);
    drive(0, 4'h0); tick();
    hit_cycles = 0;
    for (int i = 0; i < 20; i++) begin
      if (!hit) break;
      hit_cycles++;
      tick();
    end
    chk("sat.hit_cycles", 32'(hit_cycles), 32'd15);
    chk_all("sat.wait", 2'd0, 4'd0, 1'b1);
    tick(); chk_all("sat.ovf_hold", 2'd0, 4'd0, 1'b1);
    drive(1, 4'h3); tick(); chk_all("sat.ovf_clr", 2'd1, 4'd0, 1'b0);
    drive(0, 4'h0); tick(); chk_all("sat.back", 2'd0, 4'd0, 1'b0);

    // Masking: mask=C seq=8 samples 9,B,4
    mask = 4'hC; seq = 4'h8;
    drive(1, 4'h9); tick(); chk_all("mask.s0", 2'd1, 4'd1, 1'b0);
    drive(1, 4'hB); tick(); chk_all("mask.s1", 2'd1, 4'd2, 1'b0);
    drive(1, 4'h4); tick(); chk_all("mask.s2", 2'd1, 4'd2, 1'b0);
    drive(0, 4'h0); tick(); chk_all("mask.a", 2'd2, 4'd2, 1'b0);
    tick(); tick(); chk_all("mask.done", 2'd0, 4'd0, 1'b0);

    // mask=0 matches everything, then async reset mid-ASSERT
    mask = 4'h0; seq = 4'h5;
    drive(1, 4'h0); tick();
    drive(1, 4'hF); tick(); chk_all("mask0.fill", 2'd1, 4'd2, 1'b0);
    drive(0, 4'h0); hit_ready = 1'b0; tick(); chk_all("rst.pre", 2'd2, 4'd2, 1'b0);
    #2 reset = 1'b1;
    #1 chk_all("rst.async", 2'd0, 4'd0, 1'b0);
    tick();
    reset = 1'b0; hit_ready = 1'b1;
    tick(); chk_all("rst.after", 2'd0, 4'd0, 1'b0);

`ifdef PCF_ABORT_EN
    // Abort mid-WATCH
    mask = 4'hF; seq = 4'h5;
    drive(1, 4'h5); tick();
    drive(1, 4'h5); tick(); chk_all("abort.fill", 2'd1, 4'd2, 1'b0);
    abort = 1'b1; drive(1, 4'h5); tick(); chk_all("abort.hit", 2'd0, 4'd0, 1'b0);
    abort = 1'b0; drive(0, 4'h0); tick(); chk_all("abort.after", 2'd0, 4'd0, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
